// File: rtl/signed_add_ovf_pipe_if.sv
// Stream + statistics bundle for signed_add_ovf_pipe.
// master = producer/consumer side, slave = the adder block.
interface signed_add_ovf_pipe_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     sum;
  logic             overflow;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_count;
  logic             clr_stats;

  modport master (
    output in_valid, a, b, out_ready, clr_stats,
    input  in_ready, out_valid, sum, overflow, ovf_sticky, ovf_count
  );

  modport slave (
    input  in_valid, a, b, out_ready, clr_stats,
    output in_ready, out_valid, sum, overflow, ovf_sticky, ovf_count
  );
endinterface

// File: rtl/signed_add_ovf_pipe.sv
// Pipelined signed adder with valid/ready stream, overflow flag and overflow statistics.
// Define SIGNED_ADD_OVF_PIPE_SATURATE_EN to saturate overflowed sums instead of wrapping.
module signed_add_ovf_pipe #(
  parameter int W      = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  signed_add_ovf_pipe_if.slave s
);
  logic [STAGES:1]        r_vld;
  logic [STAGES:1][W-1:0] r_sum;
  logic [STAGES:1]        r_ovf;
  logic [STAGES:1]        w_adv;
  logic [W-1:0]           w_raw;
  logic [W-1:0]           w_res;
  logic                   w_ovf;
  logic                   w_evt;
  logic                   r_sticky;
  logic [CNT_W-1:0]       r_cnt;

  assign w_raw = s.a + s.b;
  assign w_ovf = (s.a[W-1] == s.b[W-1]) && (w_raw[W-1] != s.a[W-1]);

`ifdef SIGNED_ADD_OVF_PIPE_SATURATE_EN
  assign w_res = !w_ovf    ? w_raw :
                 s.a[W-1]  ? {1'b1, {(W-1){1'b0}}} :
                             {1'b0, {(W-1){1'b1}}};
`else
  assign w_res = w_raw;
`endif

  // A stage may advance unless it and every stage after it is full and the
  // consumer is stalling; written per stage so the chain has no self-loop.
  genvar k;
  generate
    for (k = 1; k <= STAGES; k++) begin : g_adv
      assign w_adv[k] = s.out_ready || !(&r_vld[STAGES:k]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_sum <= '0;
      r_ovf <= '0;
    end else begin
      if (w_adv[1]) begin
        r_vld[1] <= s.in_valid;
        if (s.in_valid) begin
          r_sum[1] <= w_res;
          r_ovf[1] <= w_ovf;
        end
      end
      for (int i = 2; i <= STAGES; i++) begin
        if (w_adv[i]) begin
          r_vld[i] <= r_vld[i-1];
          if (r_vld[i-1]) begin
            r_sum[i] <= r_sum[i-1];
            r_ovf[i] <= r_ovf[i-1];
          end
        end
      end
    end
  end

  assign w_evt = r_vld[STAGES] && s.out_ready && r_ovf[STAGES];

  // A counted event beats a simultaneous clear: the clear lands first, then the event counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_evt) begin
      r_sticky <= 1'b1;
      if (s.clr_stats)
        r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + 1'b1;
    end else if (s.clr_stats) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end
  end

  assign s.in_ready   = w_adv[1];
  assign s.out_valid  = r_vld[STAGES];
  assign s.sum        = r_sum[STAGES];
  assign s.overflow   = r_ovf[STAGES];
  assign s.ovf_sticky = r_sticky;
  assign s.ovf_count  = r_cnt;
endmodule
